// File: rtl/psum_pkg.sv
// Shared types for the psum read-modify-write accumulator.
// Holds the FSM encoding and the lane count.
package psum_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam int LANES = 2;

endpackage

// File: rtl/psum_accum_if.sv
// Bus bundle between the accumulator, its config/PE source,
// the psum memory and the output writer.
interface psum_accum_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int PASS_WIDTH = 4
);

  logic                  i_cfg_start;
  logic [ADDR_WIDTH-1:0] i_cfg_len;
  logic [PASS_WIDTH-1:0] i_cfg_passes;

  logic                  i_psum_valid;
  logic                  o_psum_ready;
  logic [DATA_WIDTH-1:0] i_psum_data0;
  logic [DATA_WIDTH-1:0] i_psum_data1;

  logic                  o_pm_wr_en;
  logic [ADDR_WIDTH-1:0] o_pm_wr_addr0;
  logic [ADDR_WIDTH-1:0] o_pm_wr_addr1;
  logic [DATA_WIDTH-1:0] o_pm_wr_data0;
  logic [DATA_WIDTH-1:0] o_pm_wr_data1;

  logic                  o_pm_rd_en;
  logic [ADDR_WIDTH-1:0] o_pm_rd_addr0;
  logic [ADDR_WIDTH-1:0] o_pm_rd_addr1;
  logic [DATA_WIDTH-1:0] i_pm_rd_data0;
  logic [DATA_WIDTH-1:0] i_pm_rd_data1;

  logic                  o_out_valid;
  logic                  i_out_ready;
  logic [DATA_WIDTH-1:0] o_out_data0;
  logic [DATA_WIDTH-1:0] o_out_data1;

  logic                  o_busy;
  logic                  o_done;

  modport master (
    output i_cfg_start, i_cfg_len, i_cfg_passes,
    output i_psum_valid, i_psum_data0, i_psum_data1,
    output i_pm_rd_data0, i_pm_rd_data1,
    output i_out_ready,
    input  o_psum_ready,
    input  o_pm_wr_en, o_pm_wr_addr0, o_pm_wr_addr1,
    input  o_pm_wr_data0, o_pm_wr_data1,
    input  o_pm_rd_en, o_pm_rd_addr0, o_pm_rd_addr1,
    input  o_out_valid, o_out_data0, o_out_data1,
    input  o_busy, o_done
  );

  modport slave (
    input  i_cfg_start, i_cfg_len, i_cfg_passes,
    input  i_psum_valid, i_psum_data0, i_psum_data1,
    input  i_pm_rd_data0, i_pm_rd_data1,
    input  i_out_ready,
    output o_psum_ready,
    output o_pm_wr_en, o_pm_wr_addr0, o_pm_wr_addr1,
    output o_pm_wr_data0, o_pm_wr_data1,
    output o_pm_rd_en, o_pm_rd_addr0, o_pm_rd_addr1,
    output o_out_valid, o_out_data0, o_out_data1,
    output o_busy, o_done
  );

endinterface

// File: rtl/psum_sat_add.sv
// Signed saturating adder, one per lane.
// Overflow shows as a mismatch of the two top bits of the wide sum.
module psum_sat_add #(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] sum_o
);

  localparam int DW = DATA_WIDTH;
  localparam logic [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

  logic [DW:0] wide_d;

  assign wide_d = {a_i[DW-1], a_i} + {b_i[DW-1], b_i};

  // Clamp to the representable range on overflow
  always_comb begin
    sum_o = wide_d[DW-1:0];
    if (wide_d[DW] != wide_d[DW-1]) begin
      sum_o = wide_d[DW] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/psum_accum.sv
// Read-modify-write psum accumulator: overwrite on pass 0, add on later
// passes, stream final (optionally ReLU'd) sums on the last pass.
module psum_accum
  import psum_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int PASS_WIDTH = 4,
  parameter bit RELU_EN    = 1'b1
) (
  input logic         i_clk,
  input logic         i_rst_n,
  psum_accum_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int PW = PASS_WIDTH;

  typedef logic signed [DW-1:0] data_t;

  state_e        state_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] k_q;
  logic [PW-1:0] passes_q;
  logic [PW-1:0] p_q;
  logic          busy_q;
  logic          done_q;
  logic          out_valid_q;
  data_t         out_q [LANES];

  data_t         psum_d [LANES];
  data_t         rd_d   [LANES];
  data_t         sum_d  [LANES];
  data_t         wr_d   [LANES];
  data_t         relu_d [LANES];
  logic [AW-1:0] addr_d [LANES];

  logic in_accum;
  logic first_pass;
  logic last_pass;
  logic last_beat;
  logic out_free;
  logic ready_d;
  logic accept_d;
  logic rd_en_d;

  assign psum_d[0] = bus.i_psum_data0;
  assign psum_d[1] = bus.i_psum_data1;
  assign rd_d[0]   = bus.i_pm_rd_data0;
  assign rd_d[1]   = bus.i_pm_rd_data1;

  assign in_accum   = (state_q == S_ACCUM);
  assign first_pass = (p_q == '0);
  assign last_pass  = (p_q == passes_q - 1'b1);
  assign last_beat  = (k_q == len_q - 1'b1);
  assign out_free   = !out_valid_q || bus.i_out_ready;
  assign ready_d    = in_accum && (!last_pass || out_free);
  assign accept_d   = bus.i_psum_valid && ready_d;
  assign rd_en_d    = accept_d && !first_pass;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign addr_d[l] = {k_q[AW-2:0], 1'(l)};

    psum_sat_add #(
      .DATA_WIDTH(DW)
    ) u_add (
      .a_i  (rd_d[l]),
      .b_i  (psum_d[l]),
      .sum_o(sum_d[l])
    );

    assign wr_d[l]   = first_pass ? psum_d[l] : sum_d[l];
    assign relu_d[l] = (RELU_EN && wr_d[l][DW-1]) ? '0 : wr_d[l];
  end

  assign bus.o_psum_ready  = ready_d;
  assign bus.o_pm_wr_en    = accept_d;
  assign bus.o_pm_wr_addr0 = accept_d ? addr_d[0] : '0;
  assign bus.o_pm_wr_addr1 = accept_d ? addr_d[1] : '0;
  assign bus.o_pm_wr_data0 = accept_d ? wr_d[0] : '0;
  assign bus.o_pm_wr_data1 = accept_d ? wr_d[1] : '0;
  assign bus.o_pm_rd_en    = rd_en_d;
  assign bus.o_pm_rd_addr0 = rd_en_d ? addr_d[0] : '0;
  assign bus.o_pm_rd_addr1 = rd_en_d ? addr_d[1] : '0;
  assign bus.o_out_valid   = out_valid_q;
  assign bus.o_out_data0   = out_q[0];
  assign bus.o_out_data1   = out_q[1];
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;

  // Tile sequencing: config latch, beat/pass counters, busy/done
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      passes_q <= '0;
      k_q      <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.i_cfg_start) begin
            len_q    <= bus.i_cfg_len;
            passes_q <= bus.i_cfg_passes;
            k_q      <= '0;
            p_q      <= '0;
            busy_q   <= 1'b1;
            if (bus.i_cfg_len == '0 || bus.i_cfg_passes == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (accept_d) begin
            if (last_beat) begin
              k_q <= '0;
              if (last_pass) begin
                state_q <= S_FLUSH;
              end else begin
                p_q <= p_q + 1'b1;
              end
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (!out_valid_q) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // One-entry output register; a new load wins over a drain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_q <= 1'b0;
      out_q[0]    <= '0;
      out_q[1]    <= '0;
    end else if (accept_d && last_pass) begin
      out_valid_q <= 1'b1;
      out_q[0]    <= relu_d[0];
      out_q[1]    <= relu_d[1];
    end else if (out_valid_q && bus.i_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
